// File: rtl/utils.sv
// rtl/utils.sv - shared types and constants for the instruction fetch slice
package utils;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instruction;
  } fetch_fifo_data;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - first-word-fall-through queue with synchronous flush and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty     = (cnt == '0);
  assign full      = (cnt == DEPTH_C);
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  // Flush wins over both push and pop; a push into a full queue is dropped.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + ONE_C;
        2'b01:   cnt <= cnt - ONE_C;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC sequencer, in-flight tracker and credit-based issue feeding fetch_fifo
module fetch_queue
  import utils::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_dispatch_rd_en,
  input  logic        i_jmp_valid,
  input  logic [31:0] i_jmp_br_addr,
  output logic        o_imem_rd_en,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_fetch_pc_plus_4,
  output logic [31:0] o_fetch_instruction,
  output logic        o_fetch_empty_flag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]    pc;
  logic [31:0]    inflight_pc;
  logic           inflight;
  logic [CW-1:0]  count;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic           issue;
  logic [CW:0]    occupancy;
  fetch_fifo_data push_data;
  fetch_fifo_data head_data;

  assign pop  = i_dispatch_rd_en && !empty;
  assign push = inflight;

  // Entries already committed to the queue after this cycle, counting the read in flight.
  assign occupancy = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight};
  assign issue     = i_rst_n && !i_jmp_valid && (occupancy < DEPTH_C);

  assign o_imem_rd_en = issue;
  assign o_imem_addr  = pc;

  assign push_data.pc_plus_4   = inflight_pc + PC_STEP;
  assign push_data.instruction = i_imem_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= pc;
      if (i_jmp_valid) pc <= i_jmp_br_addr;
      else if (issue)  pc <= pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_fifo_data))
  ) u_fetch_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .flush     (i_jmp_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  assign o_fetch_empty_flag  = empty;
  assign o_fetch_pc_plus_4   = empty ? 32'h0 : head_data.pc_plus_4;
  assign o_fetch_instruction = empty ? 32'h0 : head_data.instruction;

  // The credit rule must keep every memory return landing in a free slot.
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push && full && !i_jmp_valid));

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        dispatch_rd_en;
  logic        jmp_valid;
  logic [31:0] jmp_br_addr;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] fetch_pc_plus_4;
  logic [31:0] fetch_instruction;
  logic        fetch_empty_flag;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_dispatch_rd_en    (dispatch_rd_en),
    .i_jmp_valid         (jmp_valid),
    .i_jmp_br_addr       (jmp_br_addr),
    .o_imem_rd_en        (imem_rd_en),
    .o_imem_addr         (imem_addr),
    .i_imem_data         (imem_data),
    .o_fetch_pc_plus_4   (fetch_pc_plus_4),
    .o_fetch_instruction (fetch_instruction),
    .o_fetch_empty_flag  (fetch_empty_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at byte address a holds a ^ 0x5A5A0000.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (imem_rd_en) imem_data <= imem(imem_addr);
  end

  task automatic next_cycle(input logic pop_v, input logic jmp_v, input logic [31:0] tgt);
    @(negedge clk);
    dispatch_rd_en = pop_v;
    jmp_valid      = jmp_v;
    jmp_br_addr    = tgt;
    #1;
  endtask

  task automatic apply_reset(input logic pop_v);
    @(negedge clk);
    rst_n          = 1'b0;
    dispatch_rd_en = 1'b0;
    jmp_valid      = 1'b0;
    @(negedge clk);
    dispatch_rd_en = pop_v;
    rst_n          = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    checks++; if (fetch_empty_flag !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", fetch_empty_flag); end
    checks++; if (fetch_pc_plus_4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", fetch_pc_plus_4); end
    checks++; if (fetch_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", fetch_instruction); end
  endtask

  task automatic test_pop_empty;
    logic [31:0] exp_pc4;
    apply_reset(1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle(1'b1, 1'b0, 32'h0);
      exp_pc4 = (k < 2) ? 32'h0 : 32'(4 * (k - 1));
      checks++; if (fetch_empty_flag !== (k < 2)) begin errors++; $display("FAIL pop_empty_flag c%0d got=%b exp=%b", k, fetch_empty_flag, (k < 2)); end
      checks++; if (fetch_pc_plus_4 !== exp_pc4) begin errors++; $display("FAIL pop_empty_pc4 c%0d got=%h exp=%h", k, fetch_pc_plus_4, exp_pc4); end
      if (k >= 2) begin
        checks++; if (fetch_instruction !== imem(32'(4 * (k - 2)))) begin errors++; $display("FAIL pop_empty_instr c%0d got=%h exp=%h", k, fetch_instruction, imem(32'(4 * (k - 2)))); end
      end
      if (k == 1) begin
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL pop_empty_count got=%0d exp=0", dut.count); end
      end
    end
  endtask

  task automatic test_fill;
    apply_reset(1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle(1'b0, 1'b0, 32'h0);
      checks++; if (imem_rd_en !== (k < 4)) begin errors++; $display("FAIL fill_rd_en c%0d got=%b exp=%b", k, imem_rd_en, (k < 4)); end
      if (k < 4) begin
        checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL fill_addr c%0d got=%h exp=%h", k, imem_addr, 32'(4 * k)); end
      end
    end
    checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", dut.count); end
    checks++; if (fetch_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL fill_head_pc4 got=%h exp=4", fetch_pc_plus_4); end
    checks++; if (fetch_instruction !== 32'h5A5A_0000) begin errors++; $display("FAIL fill_head_instr got=%h exp=5a5a0000", fetch_instruction); end
  endtask

  task automatic test_stream;
    for (int j = 0; j < 10; j++) begin
      next_cycle(1'b1, 1'b0, 32'h0);
      checks++; if (fetch_empty_flag !== 1'b0) begin errors++; $display("FAIL stream_empty c%0d got=%b exp=0", j, fetch_empty_flag); end
      checks++; if (fetch_pc_plus_4 !== 32'(4 * (j + 1))) begin errors++; $display("FAIL stream_pc4 c%0d got=%h exp=%h", j, fetch_pc_plus_4, 32'(4 * (j + 1))); end
      checks++; if (fetch_instruction !== imem(32'(4 * j))) begin errors++; $display("FAIL stream_instr c%0d got=%h exp=%h", j, fetch_instruction, imem(32'(4 * j))); end
      checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'(16 + 4 * j)) begin errors++; $display("FAIL stream_issue c%0d got=%b/%h exp=1/%h", j, imem_rd_en, imem_addr, 32'(16 + 4 * j)); end
    end
  endtask

  task automatic test_jump;
    next_cycle(1'b0, 1'b1, 32'h100);
    checks++; if (dut.count !== 3'd3) begin errors++; $display("FAIL jump_pre_count got=%0d exp=3", dut.count); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL jump_n_rd_en got=%b exp=0", imem_rd_en); end
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (fetch_empty_flag !== 1'b1) begin errors++; $display("FAIL jump_n1_empty got=%b exp=1", fetch_empty_flag); end
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL jump_n1_issue got=%b/%h exp=1/100", imem_rd_en, imem_addr); end
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (fetch_empty_flag !== 1'b1) begin errors++; $display("FAIL jump_n2_empty got=%b exp=1", fetch_empty_flag); end
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (fetch_empty_flag !== 1'b0) begin errors++; $display("FAIL jump_n3_empty got=%b exp=0", fetch_empty_flag); end
    checks++; if (fetch_pc_plus_4 !== 32'h104) begin errors++; $display("FAIL jump_n3_pc4 got=%h exp=104", fetch_pc_plus_4); end
    checks++; if (fetch_instruction !== 32'h5A5A_0100) begin errors++; $display("FAIL jump_n3_instr got=%h exp=5a5a0100", fetch_instruction); end
  endtask

  task automatic test_push_pop;
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL pp_count_n4 got=%0d exp=2", dut.count); end
    for (int j = 0; j < 3; j++) begin
      next_cycle(1'b1, 1'b0, 32'h0);
      checks++; if (dut.count !== 3'd3) begin errors++; $display("FAIL pp_count c%0d got=%0d exp=3", j, dut.count); end
      checks++; if (fetch_pc_plus_4 !== 32'(32'h104 + 4 * j)) begin errors++; $display("FAIL pp_pc4 c%0d got=%h exp=%h", j, fetch_pc_plus_4, 32'(32'h104 + 4 * j)); end
    end
  endtask

  task automatic test_double_jump;
    next_cycle(1'b0, 1'b1, 32'h200);
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL djump_a_rd_en got=%b exp=0", imem_rd_en); end
    next_cycle(1'b0, 1'b1, 32'h300);
    checks++; if (imem_rd_en !== 1'b0 || fetch_empty_flag !== 1'b1) begin errors++; $display("FAIL djump_b got=%b/%b exp=0/1", imem_rd_en, fetch_empty_flag); end
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h300 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL djump_issue got=%b/%h exp=1/300", imem_rd_en, imem_addr); end
    next_cycle(1'b0, 1'b0, 32'h0);
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (fetch_pc_plus_4 !== 32'h304 || fetch_instruction !== 32'h5A5A_0300) begin errors++; $display("FAIL djump_head got=%h/%h exp=304/5a5a0300", fetch_pc_plus_4, fetch_instruction); end
  endtask

  task automatic test_reset_midstream;
    next_cycle(1'b1, 1'b0, 32'h0);
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_issue got=%b exp=1", imem_rd_en); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_rd_en !== 1'b0 || fetch_empty_flag !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl got=%b/%b exp=0/1", imem_rd_en, fetch_empty_flag); end
    checks++; if (fetch_pc_plus_4 !== 32'h0 || fetch_instruction !== 32'h0) begin errors++; $display("FAIL rst_mid_head got=%h/%h exp=0/0", fetch_pc_plus_4, fetch_instruction); end
    dispatch_rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_restart got=%b/%h exp=1/0", imem_rd_en, imem_addr); end
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (fetch_empty_flag !== 1'b1) begin errors++; $display("FAIL rst_mid_c1_empty got=%b exp=1", fetch_empty_flag); end
    next_cycle(1'b0, 1'b0, 32'h0);
    checks++; if (fetch_pc_plus_4 !== 32'h4 || fetch_instruction !== 32'h5A5A_0000) begin errors++; $display("FAIL rst_mid_c2_head got=%h/%h exp=4/5a5a0000", fetch_pc_plus_4, fetch_instruction); end
    checks++; if (dut.count !== 3'd1) begin errors++; $display("FAIL rst_mid_c2_count got=%0d exp=1", dut.count); end
  endtask

  initial begin
    rst_n          = 1'b0;
    dispatch_rd_en = 1'b0;
    jmp_valid      = 1'b0;
    jmp_br_addr    = 32'h0;
    imem_data      = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    test_pop_empty;
    test_fill;
    test_stream;
    test_jump;
    test_push_pop;
    test_double_jump;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
